// File: rtl/sms_alarm_dispatcher.sv
// Message composer/arbiter in front of the gsm SMS sender: queues user and alarm events,
// builds one text/phone pair at a time, pulses msg_start and waits for msg_done or a timeout.
module sms_alarm_dispatcher #(
   parameter int N_CH            = 3,
   parameter int TEXT_W          = 384,
   parameter int PHONE_DIGITS    = 11,
   parameter int ADDR_W          = 5,
   parameter int ROOMS_PER_FLOOR = 4,
   parameter int FLOORS          = 4,
   parameter int ROOM_POS        = 36,
   parameter int FLOOR_POS       = 46,
   // Byte 0 is sent first, so the literal is the message written back to front.
   parameter logic [TEXT_W-1:0] USER_TEXT = "._ :roolf ,_ moor ni derots neeb sah tcejbo ruoY",
   parameter logic [8*PHONE_DIGITS-1:0] ADMIN_PHONE = 88'h32_39_35_34_35_39_32_30_38_35_31,
   parameter int TIMEOUT_CYC     = 500_000_000
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       req_en_i,
   input  logic [ADDR_W-1:0]          room_addr_i,
   input  logic [4*PHONE_DIGITS-1:0]  cus_phone_bcd_i,
   input  logic [N_CH-1:0]            alarm_n_i,
   input  logic [N_CH-1:0]            alarm_mask_i,
   input  logic [N_CH*TEXT_W-1:0]     ch_text_i,
   input  logic                       msg_done_i,
   output logic [TEXT_W-1:0]          text_buf_o,
   output logic [8*PHONE_DIGITS-1:0]  phone_buf_o,
   output logic                       msg_start_o,
   output logic                       busy_o,
   output logic [N_CH-1:0]            pending_o,
   output logic                       addr_err_o,
   output logic                       timeout_o
);

   // state | meaning
   // IDLE  | nothing in flight; pick user request first, else lowest pending alarm
   // LOAD  | register text/phone for the chosen event, clear its queue bit
   // START | msg_start high for this single cycle, arm the wait timer
   // WAIT  | wait for msg_done; timer expiry drops the message and pulses timeout
   typedef enum logic [1:0] {IDLE, LOAD, START, WAIT} state_t;

   localparam int IDX_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam int MAX_ADDR = FLOORS * ROOMS_PER_FLOOR;

   state_t                      state_q;
   logic                        req_q;
   logic [N_CH-1:0]             al_q;
   logic                        usr_pend_q, usr_pend_d;
   logic [ADDR_W-1:0]           usr_addr_q;
   logic [4*PHONE_DIGITS-1:0]   usr_phone_q;
   logic [N_CH-1:0]             pending_q, pending_d;
   logic                        serve_usr_q;
   logic [IDX_W-1:0]            serve_idx_q;
   logic [CNT_W-1:0]            cnt_q;
   logic [TEXT_W-1:0]           text_q;
   logic [8*PHONE_DIGITS-1:0]   phone_q;
   logic                        msg_start_q, busy_q, addr_err_q, timeout_q;

   logic                        req_ev, addr_ok, usr_set;
   logic [N_CH-1:0]             al_ev, clr_mask;
   logic [IDX_W-1:0]            low_idx;
   logic [TEXT_W-1:0]           usr_text;
   logic [8*PHONE_DIGITS-1:0]   usr_phone_ascii;
   logic [31:0]                 addr_m1;

   always_comb begin
      req_ev  = req_en_i & ~req_q;
      al_ev   = al_q & ~alarm_n_i;
      addr_ok = (room_addr_i != '0) && (32'(room_addr_i) <= 32'(MAX_ADDR));
      usr_set = req_ev & addr_ok;

      clr_mask = '0;
      if (state_q == LOAD && !serve_usr_q)
         clr_mask[serve_idx_q] = 1'b1;

      // A new event on the same edge as the LOAD clear keeps the bit set.
      pending_d  = (pending_q & ~clr_mask) | (al_ev & ~alarm_mask_i);
      usr_pend_d = (usr_pend_q & ~(state_q == LOAD && serve_usr_q)) | usr_set;
   end

   always_comb begin
      low_idx = '0;
      for (int i = N_CH - 1; i >= 0; i--)
         if (pending_q[i])
            low_idx = IDX_W'(i);
   end

   always_comb begin
      addr_m1  = 32'(usr_addr_q) - 32'd1;
      usr_text = USER_TEXT;
      usr_text[FLOOR_POS*8 +: 8] = 8'h31 + 8'(addr_m1 / 32'(ROOMS_PER_FLOOR));
      usr_text[ROOM_POS*8 +: 8]  = 8'h31 + 8'(addr_m1 % 32'(ROOMS_PER_FLOOR));
      usr_phone_ascii = '0;
      for (int k = 0; k < PHONE_DIGITS; k++)
         usr_phone_ascii[k*8 +: 8] = {4'h3, usr_phone_q[k*4 +: 4]};
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         req_q       <= 1'b0;
         al_q        <= '0;
         usr_pend_q  <= 1'b0;
         usr_addr_q  <= '0;
         usr_phone_q <= '0;
         pending_q   <= '0;
         serve_usr_q <= 1'b0;
         serve_idx_q <= '0;
         cnt_q       <= '0;
         text_q      <= '0;
         phone_q     <= '0;
         msg_start_q <= 1'b0;
         busy_q      <= 1'b0;
         addr_err_q  <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         req_q       <= req_en_i;
         al_q        <= alarm_n_i;
         usr_pend_q  <= usr_pend_d;
         pending_q   <= pending_d;
         addr_err_q  <= req_ev & ~addr_ok;
         msg_start_q <= 1'b0;
         timeout_q   <= 1'b0;

         if (usr_set) begin
            usr_addr_q  <= room_addr_i;
            usr_phone_q <= cus_phone_bcd_i;
         end

         case (state_q)
            IDLE: begin
               if (usr_pend_q) begin
                  serve_usr_q <= 1'b1;
                  busy_q      <= 1'b1;
                  state_q     <= LOAD;
               end else if (|pending_q) begin
                  serve_usr_q <= 1'b0;
                  serve_idx_q <= low_idx;
                  busy_q      <= 1'b1;
                  state_q     <= LOAD;
               end
            end
            LOAD: begin
               if (serve_usr_q) begin
                  text_q  <= usr_text;
                  phone_q <= usr_phone_ascii;
               end else begin
                  text_q  <= ch_text_i[int'(serve_idx_q)*TEXT_W +: TEXT_W];
                  phone_q <= ADMIN_PHONE;
               end
               msg_start_q <= 1'b1;
               state_q     <= START;
            end
            START: begin
               cnt_q   <= CNT_W'(TIMEOUT_CYC - 1);
               state_q <= WAIT;
            end
            WAIT: begin
               if (msg_done_i) begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else if (cnt_q == '0) begin
                  timeout_q <= 1'b1;
                  busy_q    <= 1'b0;
                  state_q   <= IDLE;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign text_buf_o  = text_q;
   assign phone_buf_o = phone_q;
   assign msg_start_o = msg_start_q;
   assign busy_o      = busy_q;
   assign pending_o   = pending_q;
   assign addr_err_o  = addr_err_q;
   assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_sms_alarm_dispatcher.sv
// Directed bench for sms_alarm_dispatcher: a timeline-level event model checked every cycle,
// plus literal expectations taken from hand-worked examples.
module tb_sms_alarm_dispatcher;

   localparam int TO = 16;
   localparam logic [383:0] USER_T = {12{32'h5A_C3_96_0F}};
   localparam logic [87:0]  ADMIN  = 88'h32_39_35_34_35_39_32_30_38_35_31;
   localparam logic [383:0] CH0_T  = {24{16'hC0DE}};
   localparam logic [383:0] CH1_T  = {24{16'hC1C1}};
   localparam logic [383:0] CH2_T  = {12{32'hC2_00_FF_11}};

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          req_en_i;
   logic [4:0]    room_addr_i;
   logic [43:0]   cus_phone_bcd_i;
   logic [2:0]    alarm_n_i;
   logic [2:0]    alarm_mask_i;
   logic [1151:0] ch_text_i;
   logic          msg_done_i;
   logic [383:0]  text_buf_o;
   logic [87:0]   phone_buf_o;
   logic          msg_start_o, busy_o, addr_err_o, timeout_o;
   logic [2:0]    pending_o;

   sms_alarm_dispatcher #(
      .N_CH(3), .TEXT_W(384), .PHONE_DIGITS(11), .ADDR_W(5), .ROOMS_PER_FLOOR(4), .FLOORS(4),
      .ROOM_POS(36), .FLOOR_POS(46), .USER_TEXT(USER_T), .TIMEOUT_CYC(TO)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i), .req_en_i(req_en_i), .room_addr_i(room_addr_i),
      .cus_phone_bcd_i(cus_phone_bcd_i), .alarm_n_i(alarm_n_i), .alarm_mask_i(alarm_mask_i),
      .ch_text_i(ch_text_i), .msg_done_i(msg_done_i), .text_buf_o(text_buf_o),
      .phone_buf_o(phone_buf_o), .msg_start_o(msg_start_o), .busy_o(busy_o),
      .pending_o(pending_o), .addr_err_o(addr_err_o), .timeout_o(timeout_o)
   );

   always #5 clk_i = ~clk_i;

   int n_assert = 0;
   int n_fail   = 0;

   task automatic chk(input string nm, input logic [383:0] act, input logic [383:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [87:0] bcd2asc(input logic [43:0] b);
      logic [87:0] r;
      for (int k = 0; k < 11; k++) r[k*8 +: 8] = 8'h30 + 8'(b[k*4 +: 4]);
      return r;
   endfunction

   function automatic logic [383:0] utext(input logic [4:0] a);
      logic [383:0] t;
      int x;
      x = int'(a) - 1;
      t = USER_T;
      t[46*8 +: 8] = 8'(48 + x / 4 + 1);
      t[36*8 +: 8] = 8'(48 + x % 4 + 1);
      return t;
   endfunction

   // Model: queues as bit vectors, the dispatcher as a timeline of edge numbers.
   int           cyc = 0;
   bit           chk_en = 0;
   logic         m_req, m_usr;
   logic [2:0]   m_al, m_pend;
   logic [4:0]   m_addr;
   logic [43:0]  m_bcd;
   int           decide_at, load_at, start_at, sv_ch;
   bit           sv_user;
   logic [383:0] e_text;
   logic [87:0]  e_phone;
   logic         e_start, e_busy, e_err, e_to;

   always @(posedge clk_i) begin
      logic       req_ev, op_u;
      logic [2:0] al_ev, op_p;
      cyc++;
      chk_en = 1;
      if (rst_i) begin
         m_req = 0; m_al = 0; m_usr = 0; m_pend = 0; m_addr = 0; m_bcd = 0;
         decide_at = cyc + 1; load_at = -1; start_at = -1; sv_ch = 0; sv_user = 0;
         e_text = 0; e_phone = 0; e_start = 0; e_busy = 0; e_err = 0; e_to = 0;
      end else begin
         req_ev  = req_en_i & ~m_req;
         al_ev   = m_al & ~alarm_n_i;
         op_u    = m_usr;
         op_p    = m_pend;
         e_start = 0;
         e_to    = 0;
         e_err   = req_ev && (room_addr_i == 0 || room_addr_i > 16);
         if (cyc == decide_at) begin
            if (op_u || op_p != 0) begin
               sv_user = op_u;
               for (int i = 2; i >= 0; i--) if (op_p[i]) sv_ch = i;
               load_at = cyc + 1; decide_at = -1; e_busy = 1;
            end else decide_at = cyc + 1;
         end else if (cyc == load_at) begin
            if (sv_user) begin
               e_text = utext(m_addr); e_phone = bcd2asc(m_bcd); m_usr = 0;
            end else begin
               e_text = ch_text_i[sv_ch*384 +: 384]; e_phone = ADMIN; m_pend[sv_ch] = 0;
            end
            load_at = -1; start_at = cyc; e_start = 1;
         end else if (start_at >= 0 && cyc >= start_at + 2) begin
            if (msg_done_i || cyc == start_at + 1 + TO) begin
               e_to = !msg_done_i;
               e_busy = 0; decide_at = cyc + 1; start_at = -1;
            end
         end
         if (req_ev && !e_err) begin
            m_usr = 1; m_addr = room_addr_i; m_bcd = cus_phone_bcd_i;
         end
         m_pend = m_pend | (al_ev & ~alarm_mask_i);
         m_req = req_en_i;
         m_al  = alarm_n_i;
      end
   end

   always @(negedge clk_i) begin
      if (chk_en) begin
         chk("text_buf", text_buf_o, e_text);
         chk("phone_buf", 384'(phone_buf_o), 384'(e_phone));
         chk("msg_start", 384'(msg_start_o), 384'(e_start));
         chk("busy", 384'(busy_o), 384'(e_busy));
         chk("pending", 384'(pending_o), 384'(m_pend));
         chk("addr_err", 384'(addr_err_o), 384'(e_err));
         chk("timeout", 384'(timeout_o), 384'(e_to));
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk_i);
   endtask

   task automatic wait_start(input string nm, input int budget, output int at);
      at = -1;
      for (int i = 0; i < budget && at < 0; i++) begin
         @(negedge clk_i);
         if (msg_start_o) at = cyc;
      end
      if (at < 0) begin
         n_assert++; n_fail++;
         $display("FAIL %s: msg_start not seen within %0d cycles", nm, budget);
      end
   endtask

   task automatic send_done();
      tick(2);
      msg_done_i = 1'b1;
      tick(1);
      msg_done_i = 1'b0;
   endtask

   task automatic expect_quiet(input string nm, input int n);
      int starts = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk_i);
         if (msg_start_o) starts++;
      end
      chk(nm, 384'(starts), 384'(0));
   endtask

   initial begin
      int e, s, t;
      rst_i = 1; req_en_i = 0; room_addr_i = 0; cus_phone_bcd_i = 0; alarm_n_i = 3'b111;
      alarm_mask_i = 0; ch_text_i = {CH2_T, CH1_T, CH0_T}; msg_done_i = 0;
      tick(3);
      rst_i = 0;
      tick(2);
      chk("reset_pending", 384'(pending_o), 384'(0));
      chk("reset_busy", 384'(busy_o), 384'(0));

      // 1: user request, room 7
      room_addr_i = 7; cus_phone_bcd_i = 44'h13812345678; req_en_i = 1;
      tick(1); e = cyc;
      wait_start("s1_start", 10, s);
      chk("s1_latency", 384'(s - e), 384'(2));
      chk("s1_floor_byte", 384'(text_buf_o[46*8 +: 8]), 384'(8'h32));
      chk("s1_room_byte", 384'(text_buf_o[36*8 +: 8]), 384'(8'h33));
      chk("s1_phone", 384'(phone_buf_o), 384'(88'h31_33_38_31_32_33_34_35_36_37_38));
      req_en_i = 0;
      send_done();
      tick(2);
      chk("s1_idle", 384'(busy_o), 384'(0));

      // 2: ch0 and ch2 fall together
      alarm_n_i = 3'b010;
      tick(1);
      chk("s2_pending", 384'(pending_o), 384'(3'b101));
      wait_start("s2_start_a", 10, s);
      chk("s2_text_ch0", text_buf_o, CH0_T);
      chk("s2_phone_a", 384'(phone_buf_o), 384'(ADMIN));
      chk("s2_pending_a", 384'(pending_o), 384'(3'b100));
      send_done();
      wait_start("s2_start_b", 10, s);
      chk("s2_text_ch2", text_buf_o, CH2_T);
      chk("s2_phone_b", 384'(phone_buf_o), 384'(ADMIN));
      chk("s2_pending_b", 384'(pending_o), 384'(3'b000));
      send_done();
      alarm_n_i = 3'b111;
      tick(3);

      // 3: user request and ch1 on the same edge
      room_addr_i = 16; req_en_i = 1; alarm_n_i = 3'b101;
      tick(1);
      wait_start("s3_start_user", 10, s);
      chk("s3_floor_byte", 384'(text_buf_o[46*8 +: 8]), 384'(8'h34));
      chk("s3_room_byte", 384'(text_buf_o[36*8 +: 8]), 384'(8'h34));
      chk("s3_pending", 384'(pending_o), 384'(3'b010));
      send_done();
      wait_start("s3_start_ch1", 10, s);
      chk("s3_text_ch1", text_buf_o, CH1_T);
      send_done();
      req_en_i = 0; alarm_n_i = 3'b111;
      tick(3);

      // 4: masked channel
      alarm_mask_i = 3'b010; alarm_n_i = 3'b101;
      tick(1);
      chk("s4_pending", 384'(pending_o), 384'(0));
      expect_quiet("s4_masked_quiet", 8);
      alarm_mask_i = 3'b000;
      expect_quiet("s4_unmask_quiet", 8);
      alarm_n_i = 3'b111;
      tick(2);

      // 5: timeout on ch0, ch2 queued meanwhile
      alarm_n_i = 3'b110;
      tick(1);
      wait_start("s5_start", 10, s);
      alarm_n_i = 3'b010;
      t = -1;
      for (int i = 0; i < 40 && t < 0; i++) begin
         @(negedge clk_i);
         if (timeout_o) t = cyc;
      end
      chk("s5_timeout_after_start_drop", 384'(t - (s + 1)), 384'(16));
      chk("s5_busy_after_timeout", 384'(busy_o), 384'(0));
      wait_start("s5_start_ch2", 10, s);
      chk("s5_text_ch2", text_buf_o, CH2_T);
      send_done();
      alarm_n_i = 3'b111;
      tick(2);

      // 6: invalid room addresses, then reset during WAIT
      room_addr_i = 0; req_en_i = 1;
      tick(1);
      chk("s6_err_0", 384'(addr_err_o), 384'(1));
      req_en_i = 0;
      tick(1);
      chk("s6_err_clear", 384'(addr_err_o), 384'(0));
      room_addr_i = 17; req_en_i = 1;
      tick(1);
      chk("s6_err_17", 384'(addr_err_o), 384'(1));
      req_en_i = 0;
      expect_quiet("s6_err_quiet", 8);
      room_addr_i = 5; req_en_i = 1;
      tick(1);
      wait_start("s6_start", 10, s);
      req_en_i = 0; alarm_n_i = 3'b101;
      tick(2);
      rst_i = 1;
      tick(1);
      rst_i = 0;
      chk("s6_rst_pending", 384'(pending_o), 384'(0));
      chk("s6_rst_busy", 384'(busy_o), 384'(0));
      chk("s6_rst_text", text_buf_o, 384'(0));
      chk("s6_rst_phone", 384'(phone_buf_o), 384'(0));
      tick(2);
      alarm_n_i = 3'b111;
      expect_quiet("s6_rst_quiet", 10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
